// File: rtl/inst_mem_loader_pkg.sv
// Shared types for the boot-time instruction memory loader.
// Holds the loader FSM encoding and the byte/word bus types.
package inst_mem_loader_pkg;

    typedef enum logic [1:0] {
        LdHdrHi = 2'd0,
        LdHdrLo = 2'd1,
        LdData  = 2'd2,
        LdDone  = 2'd3
    } ld_state_e;

    typedef logic [7:0]  ld_byte_bus_t;
    typedef logic [31:0] reg_bus_t;

endpackage

// File: rtl/inst_mem_loader_if.sv
// Byte-wide valid/ready load stream into the instruction memory.
// Ports: ld_valid/ld_data from master, ld_ready from slave.
interface inst_mem_loader_if;
    import inst_mem_loader_pkg::*;

    logic         ld_valid;
    ld_byte_bus_t ld_data;
    logic         ld_ready;

    modport master (output ld_valid, output ld_data, input ld_ready);
    modport slave  (input ld_valid, input ld_data, output ld_ready);

endinterface

// File: rtl/inst_mem_loader_ld_word_asm.sv
// Assembles big-endian bytes into 32-bit words.
// Ports: clk/rst, byte_i + stb_i (byte accepted), clr_i (restart word),
// word_o (assembled word), word_stb_o (4th byte accepted this cycle).
module ld_word_asm
    import inst_mem_loader_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  ld_byte_bus_t byte_i,
    input  logic         stb_i,
    input  logic         clr_i,
    output reg_bus_t     word_o,
    output logic         word_stb_o
);

    logic [23:0] sh_q, sh_d;
    logic [1:0]  bidx_q, bidx_d;

    always_comb begin
        sh_d   = sh_q;
        bidx_d = bidx_q;
        if (clr_i) begin
            sh_d   = '0;
            bidx_d = '0;
        end else if (stb_i) begin
            sh_d   = {sh_q[15:0], byte_i};
            bidx_d = bidx_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q   <= '0;
            bidx_q <= '0;
        end else begin
            sh_q   <= sh_d;
            bidx_q <= bidx_d;
        end
    end

    // Word is presented combinationally with its last byte so the parent
    // can write it on the same edge that accepts that byte.
    assign word_o     = {sh_q, byte_i};
    assign word_stb_o = stb_i && !clr_i && (bidx_q == 2'd3);

endmodule

// File: rtl/inst_mem_loader.sv
// Boot-time instruction memory: loads an image over a byte stream, holds
// the core in reset until complete, then serves combinational fetches.
// Ports: clk, rst, ld (load stream slave), rom_ce_i/rom_addr_i (fetch),
// rom_data_o, core_rst_o, load_done_o, ovf_o.
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    inst_mem_loader_if.slave        ld,
    input  logic                    rom_ce_i,
    input  reg_bus_t                rom_addr_i,
    output reg_bus_t                rom_data_o,
    output logic                    core_rst_o,
    output logic                    load_done_o,
    output logic                    ovf_o
);

    localparam int unsigned Depth = 32'd1 << ADDR_WIDTH;

    ld_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] idx_q, idx_d;
    logic        ovf_q, ovf_d;

    logic        xfer;
    logic [15:0] hdr_cnt;
    logic        asm_stb;
    logic        asm_clr;
    reg_bus_t    asm_word;
    logic        asm_word_stb;
    logic        mem_we;

    reg_bus_t    mem [Depth];

    assign ld.ld_ready  = (state_q != LdDone);
    assign xfer         = ld.ld_valid && ld.ld_ready;
    assign hdr_cnt      = {cnt_q[15:8], ld.ld_data};
    assign core_rst_o   = (state_q != LdDone);
    assign load_done_o  = (state_q == LdDone);
    assign ovf_o        = ovf_q;

    ld_word_asm u_asm (
        .clk        (clk),
        .rst        (rst),
        .byte_i     (ld.ld_data),
        .stb_i      (asm_stb),
        .clr_i      (asm_clr),
        .word_o     (asm_word),
        .word_stb_o (asm_word_stb)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        ovf_d   = ovf_q;
        asm_stb = 1'b0;
        asm_clr = 1'b0;
        unique case (state_q)
            LdHdrHi: begin
                if (xfer) begin
                    cnt_d[15:8] = ld.ld_data;
                    state_d     = LdHdrLo;
                end
            end
            LdHdrLo: begin
                if (xfer) begin
                    cnt_d[7:0] = ld.ld_data;
                    idx_d      = '0;
                    asm_clr    = 1'b1;
                    if ({16'd0, hdr_cnt} > Depth) ovf_d = 1'b1;
                    state_d = (hdr_cnt == 16'd0) ? LdDone : LdData;
                end
            end
            LdData: begin
                asm_stb = xfer;
                if (asm_word_stb) begin
                    idx_d = idx_q + 16'd1;
                    if (idx_q == cnt_q - 16'd1) state_d = LdDone;
                end
            end
            LdDone: begin
            end
            default: state_d = LdHdrHi;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LdHdrHi;
            cnt_q   <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
        end
    end

    // Words past the array depth are consumed but dropped; the array
    // itself is deliberately left untouched by rst.
    assign mem_we = asm_word_stb && ({16'd0, idx_q} < Depth);

    always_ff @(posedge clk) begin
        if (mem_we) mem[idx_q[ADDR_WIDTH-1:0]] <= asm_word;
    end

    logic fetch_hit;
    logic unused_addr_lsb;

    assign fetch_hit = rom_ce_i && load_done_o
                       && (rom_addr_i[31:ADDR_WIDTH+2] == '0);
    assign rom_data_o = fetch_hit ? mem[rom_addr_i[ADDR_WIDTH+1:2]] : '0;
    assign unused_addr_lsb = ^rom_addr_i[1:0];

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed self-checking bench for inst_mem_loader.
// Default-depth and 4-word instances share clock and reset.
module tb_inst_mem_loader;
    import inst_mem_loader_pkg::*;

    logic     clk;
    logic     rst;
    logic     ce;
    reg_bus_t addr;
    reg_bus_t rdata;
    logic     core_rst;
    logic     done;
    logic     ovf;
    logic     ce_s;
    reg_bus_t addr_s;
    reg_bus_t rdata_s;
    logic     core_rst_s;
    logic     done_s;
    logic     ovf_s;

    int checks;
    int errors;

    logic [7:0] img_a [10];
    logic [7:0] img_b [10];
    reg_bus_t   exp_s [4];

    inst_mem_loader_if ldif ();
    inst_mem_loader_if ldif_s ();

    inst_mem_loader #(.ADDR_WIDTH(10)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .ld          (ldif),
        .rom_ce_i    (ce),
        .rom_addr_i  (addr),
        .rom_data_o  (rdata),
        .core_rst_o  (core_rst),
        .load_done_o (done),
        .ovf_o       (ovf)
    );

    inst_mem_loader #(.ADDR_WIDTH(2)) u_small (
        .clk         (clk),
        .rst         (rst),
        .ld          (ldif_s),
        .rom_ce_i    (ce_s),
        .rom_addr_i  (addr_s),
        .rom_data_o  (rdata_s),
        .core_rst_o  (core_rst_s),
        .load_done_o (done_s),
        .ovf_o       (ovf_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ldif.ld_valid = 1'b0;
        ldif_s.ld_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        ce = 1'b1;
        addr = 32'h0;
        #1;
        checks++;
        if (ldif.ld_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b want 1", ldif.ld_ready);
        end
        checks++;
        if (core_rst !== 1'b1) begin
            errors++; $display("FAIL reset_core_rst got %b want 1", core_rst);
        end
        checks++;
        if (done !== 1'b0 || ovf !== 1'b0) begin
            errors++; $display("FAIL reset_flags got done=%b ovf=%b want 0 0", done, ovf);
        end
        checks++;
        if (rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata got %h want 0", rdata);
        end
        ce = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_basic_load();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (core_rst !== 1'b1) begin
                errors++; $display("FAIL basic_core_rst_hold byte %0d got %b want 1", k, core_rst);
            end
            ldif.ld_valid = 1'b1;
            ldif.ld_data = img_a[k];
        end
        @(negedge clk);
        ldif.ld_valid = 1'b0;
        checks++;
        if (core_rst !== 1'b0 || done !== 1'b1 || ldif.ld_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_done got core_rst=%b done=%b ready=%b want 0 1 0",
                     core_rst, done, ldif.ld_ready);
        end
        ce = 1'b1;
        addr = 32'h4;
        #1;
        checks++;
        if (rdata !== 32'h3402_0002) begin
            errors++; $display("FAIL basic_word1 got %h want 34020002", rdata);
        end
        addr = 32'h0;
        #1;
        checks++;
        if (rdata !== 32'h3401_0001) begin
            errors++; $display("FAIL basic_word0 got %h want 34010001", rdata);
        end
        ce = 1'b0;
    endtask

    task automatic test_rst_mid_load();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            ldif.ld_valid = 1'b1;
            ldif.ld_data = img_a[k];
        end
        @(negedge clk);
        ldif.ld_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (core_rst !== 1'b1 || done !== 1'b0 || ldif.ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_state got core_rst=%b done=%b ready=%b want 1 0 1",
                     core_rst, done, ldif.ld_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (core_rst !== 1'b1) begin
                errors++; $display("FAIL midrst_core_rst_hold byte %0d got %b want 1", k, core_rst);
            end
            ldif.ld_valid = 1'b1;
            ldif.ld_data = img_b[k];
        end
        @(negedge clk);
        ldif.ld_valid = 1'b0;
        checks++;
        if (core_rst !== 1'b0 || done !== 1'b1) begin
            errors++; $display("FAIL midrst_done got core_rst=%b done=%b want 0 1", core_rst, done);
        end
        ce = 1'b1;
        addr = 32'h0;
        #1;
        checks++;
        if (rdata !== 32'hAABB_CCDD) begin
            errors++; $display("FAIL midrst_word0 got %h want aabbccdd", rdata);
        end
        addr = 32'h4;
        #1;
        checks++;
        if (rdata !== 32'h1122_3344) begin
            errors++; $display("FAIL midrst_word1 got %h want 11223344", rdata);
        end
        ce = 1'b0;
    endtask

    task automatic test_toggle_load();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                errors++; $display("FAIL toggle_early_done byte %0d got %b want 0", k, done);
            end
            ldif.ld_valid = 1'b1;
            ldif.ld_data = img_a[k];
            @(negedge clk);
            ldif.ld_valid = 1'b0;
            ldif.ld_data = 8'hFF;
        end
        checks++;
        if (done !== 1'b1 || core_rst !== 1'b0) begin
            errors++; $display("FAIL toggle_done got done=%b core_rst=%b want 1 0", done, core_rst);
        end
        ce = 1'b1;
        addr = 32'h0;
        #1;
        checks++;
        if (rdata !== 32'h3401_0001) begin
            errors++; $display("FAIL toggle_word0 got %h want 34010001", rdata);
        end
        addr = 32'h4;
        #1;
        checks++;
        if (rdata !== 32'h3402_0002) begin
            errors++; $display("FAIL toggle_word1 got %h want 34020002", rdata);
        end
        ce = 1'b0;
    endtask

    task automatic test_fetch_gating();
        @(negedge clk);
        ce = 1'b0;
        addr = 32'h0;
        #1;
        checks++;
        if (rdata !== 32'h0) begin
            errors++; $display("FAIL gate_ce_low got %h want 0", rdata);
        end
        ce = 1'b1;
        addr = 32'h0000_1000;
        #1;
        checks++;
        if (rdata !== 32'h0) begin
            errors++; $display("FAIL gate_out_of_range got %h want 0", rdata);
        end
        addr = 32'h8000_0000;
        #1;
        checks++;
        if (rdata !== 32'h0) begin
            errors++; $display("FAIL gate_msb got %h want 0", rdata);
        end
        addr = 32'h0000_0003;
        #1;
        checks++;
        if (rdata !== 32'h3401_0001) begin
            errors++; $display("FAIL gate_lsb_ignored got %h want 34010001", rdata);
        end
        ce = 1'b0;
    endtask

    task automatic test_zero_hdr();
        do_reset();
        @(negedge clk);
        ldif.ld_valid = 1'b1;
        ldif.ld_data = 8'h00;
        @(negedge clk);
        ldif.ld_data = 8'h00;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || ldif.ld_ready !== 1'b0 || ovf !== 1'b0 || core_rst !== 1'b0) begin
            errors++;
            $display("FAIL zero_hdr got done=%b ready=%b ovf=%b core_rst=%b want 1 0 0 0",
                     done, ldif.ld_ready, ovf, core_rst);
        end
        ldif.ld_data = 8'h55;
        @(negedge clk);
        ldif.ld_valid = 1'b0;
        ce = 1'b1;
        addr = 32'h0;
        #1;
        checks++;
        if (rdata !== 32'h3401_0001) begin
            errors++; $display("FAIL zero_hdr_keep got %h want 34010001", rdata);
        end
        ce = 1'b0;
    endtask

    task automatic test_ovf_boundary();
        do_reset();
        @(negedge clk);
        ldif.ld_valid = 1'b1;
        ldif.ld_data = 8'h04;
        @(negedge clk);
        ldif.ld_data = 8'h00;
        @(negedge clk);
        ldif.ld_valid = 1'b0;
        checks++;
        if (ovf !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL ovf_1024 got ovf=%b done=%b want 0 0", ovf, done);
        end
        do_reset();
        @(negedge clk);
        ldif.ld_valid = 1'b1;
        ldif.ld_data = 8'h04;
        @(negedge clk);
        ldif.ld_data = 8'h01;
        @(negedge clk);
        ldif.ld_valid = 1'b0;
        checks++;
        if (ovf !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL ovf_1025 got ovf=%b done=%b want 1 0", ovf, done);
        end
        do_reset();
        checks++;
        if (ovf !== 1'b0) begin
            errors++; $display("FAIL ovf_clear got %b want 0", ovf);
        end
    endtask

    task automatic test_small_ovf();
        do_reset();
        @(negedge clk);
        ldif_s.ld_valid = 1'b1;
        ldif_s.ld_data = 8'h00;
        @(negedge clk);
        ldif_s.ld_data = 8'h05;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                if (i == 0 && j == 0) begin
                    checks++;
                    if (ovf_s !== 1'b1) begin
                        errors++; $display("FAIL small_ovf_at_hdr got %b want 1", ovf_s);
                    end
                end
                ldif_s.ld_data = 8'((i + 1) * 16 + j);
            end
        end
        @(negedge clk);
        ldif_s.ld_valid = 1'b0;
        checks++;
        if (done_s !== 1'b1 || ovf_s !== 1'b1 || core_rst_s !== 1'b0) begin
            errors++;
            $display("FAIL small_done got done=%b ovf=%b core_rst=%b want 1 1 0",
                     done_s, ovf_s, core_rst_s);
        end
        ce_s = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr_s = 32'(i * 4);
            #1;
            checks++;
            if (rdata_s !== exp_s[i]) begin
                errors++; $display("FAIL small_word%0d got %h want %h", i, rdata_s, exp_s[i]);
            end
        end
        addr_s = 32'h10;
        #1;
        checks++;
        if (rdata_s !== 32'h0) begin
            errors++; $display("FAIL small_out_of_range got %h want 0", rdata_s);
        end
        ce_s = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        img_a = '{8'h00, 8'h02, 8'h34, 8'h01, 8'h00, 8'h01,
                  8'h34, 8'h02, 8'h00, 8'h02};
        img_b = '{8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD,
                  8'h11, 8'h22, 8'h33, 8'h44};
        exp_s = '{32'h1011_1213, 32'h2021_2223, 32'h3031_3233, 32'h4041_4243};
        rst = 1'b1;
        ce = 1'b0;
        addr = '0;
        ce_s = 1'b0;
        addr_s = '0;
        ldif.ld_valid = 1'b0;
        ldif.ld_data = '0;
        ldif_s.ld_valid = 1'b0;
        ldif_s.ld_data = '0;
        test_reset();
        test_basic_load();
        test_rst_mid_load();
        test_toggle_load();
        test_fetch_gating();
        test_zero_hdr();
        test_ovf_boundary();
        test_small_ovf();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
